// File: rtl/chacha_stream_decrypt_if.sv
// chacha_stream_decrypt_if: keystream, ciphertext and plaintext channels of the
// receive-side ChaCha20 stream combiner.
//
// Handshake rule for every channel (ks_*, ct_*, pt_*): a transfer happens on the
// rising clock edge where valid and ready are both 1. The source holds its data
// and valid steady until that transfer. Ready never depends on valid.
interface chacha_stream_decrypt_if #(
    parameter int BLOCK_BITS = 512,
    parameter int BYTE_W     = 8
);
    logic [BLOCK_BITS-1:0] ks_block;
    logic                  ks_valid;
    logic                  ks_ready;
    logic [BYTE_W-1:0]     ct_byte;
    logic                  ct_valid;
    logic                  ct_ready;
    logic [BYTE_W-1:0]     pt_byte;
    logic                  pt_valid;
    logic                  pt_ready;
    logic                  flush;
    logic [31:0]           byte_cnt;

    // Environment side: keystream source, ciphertext source, plaintext sink
    modport master (
        output ks_block, ks_valid, ct_byte, ct_valid, pt_ready, flush,
        input  ks_ready, ct_ready, pt_byte, pt_valid, byte_cnt
    );

    // Combiner side
    modport slave (
        input  ks_block, ks_valid, ct_byte, ct_valid, pt_ready, flush,
        output ks_ready, ct_ready, pt_byte, pt_valid, byte_cnt
    );
endinterface

// File: rtl/chacha_stream_decrypt.sv
// chacha_stream_decrypt: XORs received ciphertext bytes with ChaCha20 keystream
// bytes, consumed strictly in order (byte 0 of each block first).
// Optional feature macro: CHACHA_DEC_PREFETCH_EN adds a shadow keystream buffer
// so the next block can be queued and swapped in with no bubble at block ends.
module chacha_stream_decrypt #(
    parameter int BLOCK_BITS = 512,
    parameter int BYTE_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    chacha_stream_decrypt_if.slave  bus,
    output logic                    o_dbg_state,
    output logic [$clog2(BLOCK_BITS/BYTE_W)-1:0] o_dbg_idx
);
    localparam int NBYTES = BLOCK_BITS / BYTE_W;
    localparam int IDX_W  = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_LOADED = 1'b1
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [BLOCK_BITS-1:0] r_buf;
    logic [BYTE_W-1:0]     r_pt_byte;
    logic                  r_pt_valid;
    logic [31:0]           r_byte_cnt;
`ifdef CHACHA_DEC_PREFETCH_EN
    logic [BLOCK_BITS-1:0] r_shadow;
    logic                  r_shadow_full;
`endif

    logic              w_ct_ready;
    logic              w_ks_ready;
    logic              w_ct_hs;
    logic              w_ks_hs;
    logic              w_blk_end;
    logic [BYTE_W-1:0] w_ks_byte;

    // Ready signals depend only on state, pt_valid and pt_ready
    assign w_ct_ready = (r_state == ST_LOADED) && (!r_pt_valid || bus.pt_ready);
`ifdef CHACHA_DEC_PREFETCH_EN
    assign w_ks_ready = (r_state == ST_EMPTY) || !r_shadow_full;
`else
    assign w_ks_ready = (r_state == ST_EMPTY);
`endif

    assign w_ct_hs   = bus.ct_valid && w_ct_ready;
    assign w_ks_hs   = bus.ks_valid && w_ks_ready;
    assign w_ks_byte = r_buf[r_idx*BYTE_W +: BYTE_W];
    // Active block finishes on its last byte or on flush (only meaningful in LOADED)
    assign w_blk_end = bus.flush || (w_ct_hs && (r_idx == LAST_IDX));

    assign bus.ks_ready = w_ks_ready;
    assign bus.ct_ready = w_ct_ready;
    assign bus.pt_byte  = r_pt_byte;
    assign bus.pt_valid = r_pt_valid;
    assign bus.byte_cnt = r_byte_cnt;
    assign o_dbg_state  = r_state;
    assign o_dbg_idx    = r_idx;

    // Buffer FSM, keystream index, output register and byte counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_idx      <= '0;
            r_buf      <= '0;
            r_pt_byte  <= '0;
            r_pt_valid <= 1'b0;
            r_byte_cnt <= '0;
`ifdef CHACHA_DEC_PREFETCH_EN
            r_shadow      <= '0;
            r_shadow_full <= 1'b0;
`endif
        end else begin
            // Output register: a new byte wins over the downstream taking the old one
            if (w_ct_hs) begin
                r_pt_byte  <= bus.ct_byte ^ w_ks_byte;
                r_pt_valid <= 1'b1;
                r_byte_cnt <= r_byte_cnt + 32'd1;
            end else if (bus.pt_ready) begin
                r_pt_valid <= 1'b0;
            end

            case (r_state)
                ST_EMPTY: begin
                    if (w_ks_hs) begin
                        r_buf   <= bus.ks_block;
                        r_idx   <= '0;
                        r_state <= ST_LOADED;
                    end
                end
                ST_LOADED: begin
                    if (w_ct_hs) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                    if (w_blk_end) begin
                        r_idx <= '0;
`ifdef CHACHA_DEC_PREFETCH_EN
                        // Promote the queued block; a block arriving this very cycle
                        // with the shadow empty goes straight to the active buffer
                        if (r_shadow_full) begin
                            r_buf         <= r_shadow;
                            r_shadow_full <= 1'b0;
                        end else if (w_ks_hs) begin
                            r_buf <= bus.ks_block;
                        end else begin
                            r_state <= ST_EMPTY;
                        end
`else
                        r_state <= ST_EMPTY;
`endif
                    end
`ifdef CHACHA_DEC_PREFETCH_EN
                    else if (w_ks_hs) begin
                        r_shadow      <= bus.ks_block;
                        r_shadow_full <= 1'b1;
                    end
`endif
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_chacha_stream_decrypt.sv
// tb_chacha_stream_decrypt: scoreboard bench for the ChaCha20 receive combiner.
// Build with +define+CHACHA_DEC_PREFETCH_EN to add the prefetch scenario.
module tb_chacha_stream_decrypt;
    localparam int BLOCK_BITS = 512;
    localparam int NBYTES     = 64;
    localparam int TIMEOUT    = 200;

    logic       clk;
    logic       rst;
    logic       dbg_state;
    logic [5:0] dbg_idx;

    chacha_stream_decrypt_if #(.BLOCK_BITS(BLOCK_BITS), .BYTE_W(8)) bus ();

    chacha_stream_decrypt #(.BLOCK_BITS(BLOCK_BITS), .BYTE_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .o_dbg_state(dbg_state),
        .o_dbg_idx  (dbg_idx)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];     // plaintext bytes expected at the output, in order
    logic [7:0] ks_q[$];      // keystream bytes not yet consumed, in order
    int         rem_q[$];     // bytes left in each loaded block
    int unsigned m_cnt;
    int         vectors;
    int         miscompares;
    bit         rand_bp;
    logic [7:0] mon_e;

    // ---------------- driver tasks ----------------
    task automatic model_load(input logic [BLOCK_BITS-1:0] blk);
        for (int k = 0; k < NBYTES; k++) ks_q.push_back(blk[8*k +: 8]);
        rem_q.push_back(NBYTES);
    endtask

    task automatic model_discard_block();
        if (rem_q.size() > 0) begin
            for (int k = 0; k < rem_q[0]; k++) void'(ks_q.pop_front());
            void'(rem_q.pop_front());
        end
    endtask

    task automatic load_block(input logic [BLOCK_BITS-1:0] blk);
        int n;
        bit ok;
        bus.ks_block = blk;
        bus.ks_valid = 1'b1;
        ok = 0;
        n  = 0;
        while (n < TIMEOUT) begin
            @(negedge clk);
            if (bus.ks_ready) begin ok = 1; break; end
            n++;
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL ks_load_timeout: ks_ready=%0b after %0d cycles, required 1", bus.ks_ready, n);
            bus.ks_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_load(blk);
        #1;
        bus.ks_valid = 1'b0;
    endtask

    task automatic flush_pulse();
        bus.flush = 1'b1;
        @(posedge clk);
        model_discard_block();
        #1;
        bus.flush = 1'b0;
    endtask

    // Offer one ciphertext byte (optionally with flush), wait for acceptance and
    // check the registered plaintext right after the accepting edge.
    task automatic send_ct(input logic [7:0] ct, input logic fl, output int waits);
        logic [7:0] e;
        bit ended;
        bit ok;
        int n;
        bus.ct_byte  = ct;
        bus.ct_valid = 1'b1;
        ok = 0;
        n  = 0;
        while (n < TIMEOUT) begin
            @(negedge clk);
            if (bus.ct_ready) begin ok = 1; break; end
            n++;
            @(posedge clk);
            #1;
            if (rand_bp) bus.pt_ready = 1'($urandom_range(0, 1));
        end
        waits = n;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL ct_accept_timeout: ct_ready=%0b after %0d cycles, required 1", bus.ct_ready, n);
            bus.ct_valid = 1'b0;
            return;
        end
        bus.flush = fl;
        @(posedge clk);
        e = ct ^ ks_q.pop_front();
        exp_q.push_back(e);
        m_cnt++;
        ended = 0;
        rem_q[0] = rem_q[0] - 1;
        if (rem_q[0] == 0) begin void'(rem_q.pop_front()); ended = 1; end
        if (fl && !ended) model_discard_block();
        #1;
        bus.flush = 1'b0;
        vectors++;
        if (bus.pt_valid !== 1'b1 || bus.pt_byte !== e) begin
            miscompares++;
            $display("FAIL pt_latency: pt_valid=%0b pt_byte=%02h, required 1 / %02h", bus.pt_valid, bus.pt_byte, e);
        end
        if (rand_bp) bus.pt_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle();
        bus.ct_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    function automatic logic [BLOCK_BITS-1:0] rand_block();
        logic [BLOCK_BITS-1:0] b;
        for (int k = 0; k < NBYTES; k++) b[8*k +: 8] = 8'($urandom_range(0, 255));
        return b;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (bus.pt_byte !== 8'h00 || bus.pt_valid !== 1'b0 || bus.ks_ready !== 1'b1 ||
            bus.ct_ready !== 1'b0 || bus.byte_cnt !== 32'd0 || dbg_state !== 1'b0 || dbg_idx !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_values: pt=%02h pv=%0b ksr=%0b ctr=%0b cnt=%0d st=%0b idx=%0d, required 00 0 1 0 0 0 0",
                     bus.pt_byte, bus.pt_valid, bus.ks_ready, bus.ct_ready, bus.byte_cnt, dbg_state, dbg_idx);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [BLOCK_BITS-1:0] blk;
        logic [7:0] cts[3];
        int w;
        cts[0] = 8'h00; cts[1] = 8'hFF; cts[2] = 8'h5A;
        for (int k = 0; k < NBYTES; k++) blk[8*k +: 8] = 8'hA5;
        load_block(blk);
        for (int i = 0; i < 3; i++) send_ct(cts[i], 1'b0, w);
        vectors++;
        if (bus.byte_cnt !== 32'd3) begin
            miscompares++;
            $display("FAIL basic_byte_cnt: byte_cnt=%0d, required 3", bus.byte_cnt);
        end
        idle();
        flush_pulse();
    endtask

    task automatic test_full_block();
        logic [BLOCK_BITS-1:0] blk;
        int w;
        for (int k = 0; k < NBYTES; k++) blk[8*k +: 8] = 8'(k);
        load_block(blk);
        for (int i = 0; i < NBYTES; i++) send_ct(8'h00, 1'b0, w);
        @(negedge clk);
        vectors++;
        if (bus.ct_ready !== 1'b0 || bus.ks_ready !== 1'b1 || dbg_state !== 1'b0) begin
            miscompares++;
            $display("FAIL block_wrap: ct_ready=%0b ks_ready=%0b state=%0b, required 0 1 0",
                     bus.ct_ready, bus.ks_ready, dbg_state);
        end
        @(posedge clk); #1;
        idle();
        load_block(rand_block());
        send_ct(8'h3C, 1'b0, w);
        idle();
        flush_pulse();
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        int w;
        load_block(rand_block());
        bus.pt_ready = 1'b0;
        send_ct(8'($urandom_range(0, 255)), 1'b0, w);
        held = bus.pt_byte;
        bus.ct_byte  = 8'($urandom_range(0, 255));
        bus.ct_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.ct_ready !== 1'b0 || bus.pt_valid !== 1'b1 || bus.pt_byte !== held) begin
                miscompares++;
                $display("FAIL backpressure_hold: cycle %0d ct_ready=%0b pt_valid=%0b pt_byte=%02h, required 0 1 %02h",
                         c, bus.ct_ready, bus.pt_valid, bus.pt_byte, held);
            end
            @(posedge clk); #1;
        end
        bus.pt_ready = 1'b1;
        send_ct(bus.ct_byte, 1'b0, w);
        rand_bp = 1;
        for (int i = 0; i < 30; i++) send_ct(8'($urandom_range(0, 255)), 1'b0, w);
        rand_bp = 0;
        bus.pt_ready = 1'b1;
        idle();
        flush_pulse();
    endtask

    task automatic test_flush();
        int w;
        load_block(rand_block());
        for (int i = 0; i < 5; i++) send_ct(8'($urandom_range(0, 255)), 1'b0, w);
        send_ct(8'($urandom_range(0, 255)), 1'b1, w);
        idle();
        @(negedge clk);
        vectors++;
        if (dbg_state !== 1'b0 || bus.ct_ready !== 1'b0 || bus.ks_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_to_empty: state=%0b ct_ready=%0b ks_ready=%0b, required 0 0 1",
                     dbg_state, bus.ct_ready, bus.ks_ready);
        end
        @(posedge clk); #1;
        load_block(rand_block());
        send_ct(8'($urandom_range(0, 255)), 1'b0, w);
        idle();
        vectors++;
        if (bus.byte_cnt !== m_cnt) begin
            miscompares++;
            $display("FAIL flush_byte_cnt: byte_cnt=%0d, required %0d", bus.byte_cnt, m_cnt);
        end
        flush_pulse();
    endtask

    task automatic test_reset_mid();
        int w;
        load_block(rand_block());
        for (int i = 0; i < 20; i++) send_ct(8'($urandom_range(0, 255)), 1'b0, w);
        bus.pt_ready = 1'b0;
        idle();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.pt_byte !== 8'h00 || bus.pt_valid !== 1'b0 || bus.ks_ready !== 1'b1 ||
            bus.ct_ready !== 1'b0 || bus.byte_cnt !== 32'd0 || dbg_idx !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_async: pt=%02h pv=%0b ksr=%0b ctr=%0b cnt=%0d idx=%0d, required 00 0 1 0 0 0",
                     bus.pt_byte, bus.pt_valid, bus.ks_ready, bus.ct_ready, bus.byte_cnt, dbg_idx);
        end
        exp_q.delete();
        ks_q.delete();
        rem_q.delete();
        m_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.pt_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.ks_ready !== 1'b1 || bus.ct_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ks_ready=%0b ct_ready=%0b, required 1 0", bus.ks_ready, bus.ct_ready);
        end
        @(posedge clk); #1;
    endtask

`ifdef CHACHA_DEC_PREFETCH_EN
    task automatic test_prefetch();
        int w;
        int stalls;
        int base;
        base = int'(m_cnt);
        load_block(rand_block());
        load_block(rand_block());
        stalls = 0;
        for (int i = 0; i < 2 * NBYTES; i++) begin
            send_ct(8'($urandom_range(0, 255)), 1'b0, w);
            stalls += w;
        end
        idle();
        vectors++;
        if (stalls != 0 || bus.byte_cnt !== 32'(base + 2 * NBYTES)) begin
            miscompares++;
            $display("FAIL prefetch_stream: stalls=%0d byte_cnt=%0d, required 0 %0d", stalls, bus.byte_cnt, base + 2 * NBYTES);
        end
        load_block(rand_block());
        load_block(rand_block());
        for (int i = 0; i < 3; i++) send_ct(8'($urandom_range(0, 255)), 1'b0, w);
        idle();
        flush_pulse();
        send_ct(8'($urandom_range(0, 255)), 1'b0, w);
        idle();
        flush_pulse();
    endtask
`endif

    // ---------------- main sequence and output monitor ----------------
    initial begin
        vectors      = 0;
        miscompares  = 0;
        m_cnt        = 0;
        rand_bp      = 0;
        rst          = 1'b1;
        bus.ks_block = '0;
        bus.ks_valid = 1'b0;
        bus.ct_byte  = 8'h00;
        bus.ct_valid = 1'b0;
        bus.pt_ready = 1'b1;
        bus.flush    = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && bus.pt_valid && bus.pt_ready) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL pt_unexpected: pt_byte=%02h, required no output", bus.pt_byte);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (bus.pt_byte !== mon_e) begin
                            miscompares++;
                            $display("FAIL pt_stream: pt_byte=%02h, required %02h", bus.pt_byte, mon_e);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_basic();
        test_full_block();
        test_backpressure();
        test_flush();
`ifdef CHACHA_DEC_PREFETCH_EN
        test_prefetch();
`endif
        test_reset_mid();
        test_basic();

        bus.pt_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pt_drain: %0d bytes never delivered, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
